pipe_addsub: RTL and testbench



---
 rtl/pipe_addsub_pkg.sv | 21 ++
 rtl/addsub_slice.sv | 26 ++
 rtl/pipe_addsub.sv | 137 +++++++++++++
 tb/tb_pipe_addsub.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared types and elaboration helpers for the pipelined adder/subtractor
package pipe_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Per-stage control record; data slices live alongside with stage-specific widths.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational ripple-carry slice built from full-adder equations
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready handshake
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + ~cin, so cout = 1 means no borrow.
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub ? ~in_cin : in_cin;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SLICE;
    localparam int DONE = LO + SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] s_new;
    logic             c_s;
    logic             v_s;
    logic             c_new;
    logic [DONE-1:0]  sum_d;
    logic [DONE-1:0]  sum_q;
    stage_ctl_t       ctl_q;

    if (k == 0) begin : g_src
      assign a_s   = in_a[SLICE-1:0];
      assign b_s   = b_eff[SLICE-1:0];
      assign c_s   = c0;
      assign v_s   = in_valid & in_ready;
      assign sum_d = s_new;
    end else begin : g_src
      assign a_s   = g_stage[k-1].g_skew.a_q[SLICE-1:0];
      assign b_s   = g_stage[k-1].g_skew.b_q[SLICE-1:0];
      assign c_s   = g_stage[k-1].ctl_q.carry;
      assign v_s   = g_stage[k-1].ctl_q.valid;
      assign sum_d = {s_new, g_stage[k-1].sum_q};
    end

    addsub_slice #(
      .W(SLICE)
    ) u_slice (
      .a   (a_s),
      .b   (b_s),
      .cin (c_s),
      .sum (s_new),
      .cout(c_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q <= '{valid: v_s, carry: c_new};
        sum_q <= sum_d;
      end
    end

    // Operand bits not yet added ride along, shrinking by one slice per stage.
    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_d = in_a[WIDTH-1:SLICE];
        assign b_d = b_eff[WIDTH-1:SLICE];
      end else begin : g_in
        assign a_d = g_stage[k-1].g_skew.a_q[WIDTH-LO-1:SLICE];
        assign b_d = g_stage[k-1].g_skew.b_q[WIDTH-LO-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (a_s[SLICE-1] == b_s[SLICE-1]) & (s_new[SLICE-1] != a_s[SLICE-1]);
          zero_q <= ~|sum_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].ctl_q.carry;
  assign out_ovf   = g_stage[STAGES-1].g_flags.ovf_q;
  assign out_zero  = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed self-checking bench for pipe_addsub (WIDTH=32, STAGES=4)
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] va [16];
  logic [31:0] vb [16];
  logic        vc [16];
  logic        vs [16];

  pipe_addsub #(
    .WIDTH (32),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {cout, ovf, zero, sum} from plain 33-bit arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {32'd0, (s ? ~c : c)};
    ov = (a[31] == be[31]) && (r[31] != a[31]);
    return {r[32], ov, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  function automatic logic [34:0] obs();
    return {out_cout, out_ovf, out_zero, out_sum};
  endfunction

  function automatic logic [34:0] exp_vec(input int i);
    return model(va[i], vb[i], vc[i], vs[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_sub   = s;
  endtask

  task automatic drive_vec(input int i);
    drive(va[i], vb[i], vc[i], vs[i]);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] esum,
                          input logic ecout, input logic eovf, input logic ezero);
    int lat;
    drive(a, b, c, s);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),      64'd4);
    check({tag, "_sum"},  64'(out_sum),  64'(esum));
    check({tag, "_cout"}, 64'(out_cout), 64'(ecout));
    check({tag, "_ovf"},  64'(out_ovf),  64'(eovf));
    check({tag, "_zero"}, 64'(out_zero), 64'(ezero));
    tick();
  endtask

  initial begin
    int got;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_outs",  64'(obs()),     64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_inready", 64'(in_ready), 64'd1);

    directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_brw",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    directed("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end

    // Streaming: eight back-to-back transactions, results one per cycle.
    for (int j = 0; j < 12; j++) begin
      if (j < 8) drive_vec(j);
      else in_valid = 1'b0;
      tick();
      if (j == 2) check("stream_early", 64'(out_valid), 64'd0);
      if (j >= 3 && j < 11) begin
        check($sformatf("stream_valid%0d", j - 3), 64'(out_valid), 64'd1);
        check($sformatf("stream_res%0d", j - 3),   64'(obs()),     64'(exp_vec(j - 3)));
      end
      if (j == 11) check("stream_end", 64'(out_valid), 64'd0);
    end

    // Backpressure: fill, stall three cycles, then drain with a simultaneous accept.
    for (int j = 0; j < 4; j++) begin
      drive_vec(8 + j);
      tick();
    end
    check("bp_full", 64'(out_valid), 64'd1);
    check("bp_head", 64'(obs()),     64'(exp_vec(8)));
    out_ready = 1'b0;
    drive_vec(12);
    #1;
    check("bp_inready", 64'(in_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", j), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold_res%0d", j),   64'(obs()),     64'(exp_vec(8)));
      check($sformatf("bp_hold_rdy%0d", j),   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    got = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        if (got < 4) check($sformatf("bp_drain%0d", got), 64'(obs()), 64'(exp_vec(9 + got)));
        else check("bp_extra", 64'(out_valid), 64'd0);
        got++;
      end
    end
    check("bp_count", 64'(got), 64'd4);

    // Reset with the output register occupied and three more in flight.
    for (int j = 0; j < 4; j++) begin
      drive_vec(j);
      tick();
    end
    in_valid = 1'b0;
    check("mid_valid_before", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_outs",  64'(obs()),     64'd0);
    tick();
    check("mid_rst_hold", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    directed("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
